// File: rtl/fp_pack_round.sv
// fp_pack_round
// Packs an unnormalized sign / exponent / 48-bit mantissa triple into an
// IEEE-754 single. Normalization moves the mantissa by one bit per cycle.
// The result is then rounded to nearest-even. Overflow, denormal results
// and zero are handled here. Only one operation is in flight at a time.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. in_ready is high only in IDLE. out_valid is
// high only in OUT. out_result and out_flags stay stable while
// out_valid && !out_ready.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_sign           result sign
//   in_exp[9:0]       signed biased exponent (two's complement)
//   in_mant[47:0]     mantissa; binary point between bits 46 and 45
//   in_sticky         OR of bits already discarded upstream
//   out_valid/out_ready output handshake
//   out_result[31:0]  packed single
//   out_flags[3:0]    {overflow, underflow, inexact, zero}
//   o_dbg_state[1:0]  current FSM state (0 IDLE, 1 NORM, 2 ROUND, 3 OUT)
module fp_pack_round #(
  parameter bit FLUSH_DENORM = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic        in_sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             r_state, w_state_nx;
  logic               r_sign, w_sign_nx;
  logic signed [11:0] r_exp, w_exp_nx;
  logic [47:0]        r_mant, w_mant_nx;
  logic               r_sticky, w_sticky_nx;
  logic [31:0]        r_result, w_result_nx;
  logic [3:0]         r_flags, w_flags_nx;

  // Rounding datapath, evaluated from the registered operand.
  logic               w_guard, w_stk, w_lsb, w_up, w_inexact;
  logic [24:0]        w_sig_raw;
  logic [23:0]        w_sig;
  logic signed [11:0] w_exp_rnd;
  logic [31:0]        w_rnd_result;
  logic [3:0]         w_rnd_flags;

  always_comb begin
    w_guard   = r_mant[22];
    w_stk     = (|r_mant[21:0]) | r_sticky;
    w_lsb     = r_mant[23];
    w_up      = w_guard & (w_stk | w_lsb);
    w_inexact = w_guard | w_stk;
    w_sig_raw = {1'b0, r_mant[46:23]} + {24'd0, w_up};
    // A rounding carry out of the 24-bit significand renormalizes by one.
    if (w_sig_raw[24]) begin
      w_sig     = w_sig_raw[24:1];
      w_exp_rnd = r_exp + 12'sd1;
    end else begin
      w_sig     = w_sig_raw[23:0];
      w_exp_rnd = r_exp;
    end

    w_rnd_flags = 4'b0000;
    if (w_exp_rnd >= 12'sd255) begin
      w_rnd_result   = {r_sign, 8'hFF, 23'd0};
      w_rnd_flags[3] = 1'b1;
      w_rnd_flags[1] = 1'b1;
    end else if (!w_sig[23]) begin
      // No hidden bit: denormal or zero. A denormal that rounded up into
      // bit 23 takes the normal branch below with exponent field 1.
      if (FLUSH_DENORM) begin
        w_rnd_result = {r_sign, 31'd0};
      end else begin
        w_rnd_result = {r_sign, 8'h00, w_sig[22:0]};
      end
      w_rnd_flags[2] = w_inexact;
      w_rnd_flags[1] = w_inexact;
    end else begin
      w_rnd_result   = {r_sign, w_exp_rnd[7:0], w_sig[22:0]};
      w_rnd_flags[1] = w_inexact;
    end
    w_rnd_flags[0] = (w_rnd_result[30:0] == 31'd0);
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nx  = r_state;
    w_sign_nx   = r_sign;
    w_exp_nx    = r_exp;
    w_mant_nx   = r_mant;
    w_sticky_nx = r_sticky;
    w_result_nx = r_result;
    w_flags_nx  = r_flags;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_nx   = in_sign;
          w_exp_nx    = {{2{in_exp[9]}}, in_exp};
          w_mant_nx   = in_mant;
          w_sticky_nx = in_sticky;
          if (in_mant == 48'd0) begin
            w_result_nx = {in_sign, 31'd0};
            w_flags_nx  = 4'b0001;
            w_state_nx  = S_OUT;
          end else begin
            w_state_nx  = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (r_mant[47]) begin
          w_sticky_nx = r_sticky | r_mant[0];
          w_mant_nx   = r_mant >> 1;
          w_exp_nx    = r_exp + 12'sd1;
        end else if (!r_mant[46] && (r_exp > 12'sd1)) begin
          w_mant_nx   = r_mant << 1;
          w_exp_nx    = r_exp - 12'sd1;
        end else if (r_exp < 12'sd1) begin
          // Denormal alignment: shift right until the exponent reaches 1.
          // Once every bit has fallen into sticky, nothing is left to align.
          w_sticky_nx = r_sticky | r_mant[0];
          w_mant_nx   = r_mant >> 1;
          w_exp_nx    = r_exp + 12'sd1;
          if (r_mant[47:1] == 47'd0) begin
            w_state_nx = S_ROUND;
          end
        end else begin
          w_state_nx = S_ROUND;
        end
      end
      S_ROUND: begin
        w_result_nx = w_rnd_result;
        w_flags_nx  = w_rnd_flags;
        w_exp_nx    = w_exp_rnd;
        w_state_nx  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_exp    <= 12'sd0;
      r_mant   <= 48'd0;
      r_sticky <= 1'b0;
      r_result <= 32'd0;
      r_flags  <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_sign   <= w_sign_nx;
      r_exp    <= w_exp_nx;
      r_mant   <= w_mant_nx;
      r_sticky <= w_sticky_nx;
      r_result <= w_result_nx;
      r_flags  <= w_flags_nx;
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_OUT);
  assign out_result  = r_result;
  assign out_flags   = r_flags;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fp_pack_round.sv
// Directed testbench for fp_pack_round.
module tb_fp_pack_round;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [1:0]  o_dbg_state;

  int n_chk;
  int n_err;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  fp_pack_round #(.FLUSH_DENORM(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .in_sticky   (in_sticky),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT idle. Presents one
  // operand, measures edges from the accepting edge to out_valid (capped at
  // 200), captures the outputs and completes the output handshake.
  task automatic do_op(input logic s, input logic [9:0] e, input logic [47:0] m,
                       input logic st, output logic [31:0] res,
                       output logic [3:0] fl, output int lat);
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    in_sticky = st;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    fl  = out_flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_chk++;
    if (out_result !== 32'd0 || out_flags !== 4'd0) begin
      n_err++;
      $display("FAIL reset_data: result=%h flags=%b want 0/0", out_result, out_flags);
    end
    n_chk++;
    if (o_dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d want 0", o_dbg_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_table(input string tag, input vec_t v[]);
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    foreach (v[i]) begin
      do_op(v[i].s, v[i].e, v[i].m, 1'b0, res, fl, lat);
      n_chk++;
      if (res !== v[i].res) begin
        n_err++;
        $display("FAIL %s[%0d]_result: got %h want %h", tag, i, res, v[i].res);
      end
      n_chk++;
      if (fl !== v[i].fl) begin
        n_err++;
        $display("FAIL %s[%0d]_flags: got %b want %b", tag, i, fl, v[i].fl);
      end
      n_chk++;
      if (lat != v[i].lat) begin
        n_err++;
        $display("FAIL %s[%0d]_latency: got %0d want %0d", tag, i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_normalize();
    vec_t v[];
    v = new[3];
    v[0] = '{1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 4'b0000, 3};
    v[1] = '{1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 4'b0000, 4};
    v[2] = '{1'b0, 10'd130, 48'h0100_0000_0000, 32'h3E00_0000, 4'b0000, 9};
    test_table("norm", v);
  endtask

  task automatic test_rounding();
    vec_t v[];
    v = new[2];
    // guard only, lsb 0: tie stays even
    v[0] = '{1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 4'b0010, 3};
    // guard with lsb 1: tie rounds up to even
    v[1] = '{1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 4'b0010, 3};
    test_table("round", v);
  endtask

  task automatic test_overflow();
    vec_t v[];
    v = new[1];
    v[0] = '{1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 32'h7F80_0000, 4'b1010, 3};
    test_table("ovf", v);
  endtask

  task automatic test_denormal();
    vec_t v[];
    v = new[3];
    v[0] = '{1'b0, 10'd0,   48'h4000_0000_0000, 32'h0040_0000, 4'b0000, 4};
    // -30: 31 right shifts leave only sticky bits -> signed zero
    v[1] = '{1'b0, 10'h3E2, 48'h4000_0000_0000, 32'h0000_0000, 4'b0111, 34};
    // largest denormal rounds up into the smallest normal
    v[2] = '{1'b0, 10'd1,   48'h3FFF_FFC0_0000, 32'h0080_0000, 4'b0010, 3};
    test_table("denorm", v);
  endtask

  task automatic test_zero();
    vec_t v[];
    v = new[1];
    v[0] = '{1'b1, 10'd77, 48'h0, 32'h8000_0000, 4'b0001, 1};
    test_table("zero", v);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_hold;
    in_sign   = 1'b0;
    in_exp    = 10'd127;
    in_mant   = 48'h4000_0000_0000;
    in_sticky = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_valid: out_valid=%b want 1 within 200 edges", out_valid);
    end
    // A second operand offered while the result is stalled.
    in_exp   = 10'd100;
    in_mant  = 48'h8000_0000_0000;
    in_valid = 1'b1;
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_result !== 32'h3F80_0000 || out_flags !== 4'b0000 ||
          out_valid !== 1'b1 || in_ready !== 1'b0)
        bad_hold++;
    end
    n_chk++;
    if (bad_hold != 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable cycles, result=%h want 3f800000", bad_hold, out_result);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (o_dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL bp_not_taken: state=%0d want 0", o_dbg_state);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    in_sign   = 1'b0;
    in_exp    = 10'd130;
    in_mant   = 48'h0100_0000_0000;
    in_sticky = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (o_dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL rst_mid_in_norm: state=%0d want 1", o_dbg_state);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_mid_discard: out_valid high %0d cycles want 0", seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 10'd0;
    in_mant   = 48'd0;
    in_sticky = 1'b0;
    out_ready = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_normalize();
    test_rounding();
    test_overflow();
    test_denormal();
    test_zero();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
